// File: rtl/id_pkg.sv
// Shared types and constants for the identifier token controller.
package id_pkg;

    typedef enum logic [1:0] {
        CC_LETTER = 2'd0,
        CC_DIGIT  = 2'd1,
        CC_DELIM  = 2'd2
    } char_class_t;

    // Tokeniser states: S_DIGIT means "started with a letter, last char was a digit".
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ALPHA = 2'd1;
    localparam logic [1:0] S_DIGIT = 2'd2;
    localparam logic [1:0] S_BAD   = 2'd3;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_UC_A = 8'h41;
    localparam logic [7:0] ASCII_UC_Z = 8'h5A;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_Z = 8'h7A;

    function automatic logic inRange(input logic [7:0] c, input logic [7:0] lo, input logic [7:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/id_char_class.sv
// Combinational ASCII classifier: letter, digit or delimiter.
module id_char_class
    import id_pkg::*;
(
    input  logic [7:0]  i_char,
    output char_class_t o_class
);

    always_comb begin
        o_class = CC_DELIM;
        if (inRange(i_char, ASCII_0, ASCII_9)) begin
            o_class = CC_DIGIT;
        end else if (inRange(i_char, ASCII_UC_A, ASCII_UC_Z) ||
                     inRange(i_char, ASCII_LC_A, ASCII_LC_Z)) begin
            o_class = CC_LETTER;
        end
    end

endmodule

// File: rtl/id_token_ctrl.sv
// Splits a character stream into alnum tokens and reports, per token, whether it is
// an identifier (starts with a letter, ends with a digit) plus its saturating length.
module id_token_ctrl
    import id_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    input  logic [7:0]       i_in_char,
    input  logic             i_in_last,
    output logic             o_in_ready,
    output logic             o_tok_valid,
    output logic             o_tok_is_id,
    output logic [LEN_W-1:0] o_tok_len,
    input  logic             i_tok_ready,
    output logic [CNT_W-1:0] o_tok_count,
    output logic [CNT_W-1:0] o_id_count,
    input  logic             i_clear,
    output logic             o_busy
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_len;
    logic             r_tokValid;
    logic             r_tokIsId;
    logic [LEN_W-1:0] r_tokLen;
    logic [CNT_W-1:0] r_tokCount;
    logic [CNT_W-1:0] r_idCount;

    char_class_t      w_class;
    logic             w_accept;
    logic             w_isAlnum;
    logic [LEN_W-1:0] w_lenInc;
    logic [1:0]       w_appState;
    logic [LEN_W-1:0] w_appLen;
    logic             w_close;
    logic             w_closeIsId;
    logic [LEN_W-1:0] w_closeLen;
    logic [1:0]       w_nextState;
    logic [LEN_W-1:0] w_nextLen;

    id_char_class u_charClass (
        .i_char  (i_in_char),
        .o_class (w_class)
    );

    assign o_in_ready = !r_tokValid || i_tok_ready;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_isAlnum  = (w_class != CC_DELIM);
    assign w_lenInc   = (r_len == LEN_MAX) ? LEN_MAX : r_len + LEN_ONE;

    // State and length the token would have after appending the current alnum char.
    always_comb begin
        w_appState = r_state;
        w_appLen   = w_lenInc;
        case (r_state)
            S_IDLE: begin
                w_appLen   = LEN_ONE;
                w_appState = (w_class == CC_DIGIT) ? S_BAD : S_ALPHA;
            end
            S_ALPHA, S_DIGIT: begin
                w_appState = (w_class == CC_DIGIT) ? S_DIGIT : S_ALPHA;
            end
            default: begin
                w_appState = S_BAD;
            end
        endcase
    end

    always_comb begin
        w_close     = 1'b0;
        w_closeIsId = 1'b0;
        w_closeLen  = r_len;
        w_nextState = r_state;
        w_nextLen   = r_len;
        if (w_accept) begin
            if (w_isAlnum && i_in_last) begin
                w_close     = 1'b1;
                w_closeIsId = (w_appState == S_DIGIT);
                w_closeLen  = w_appLen;
                w_nextState = S_IDLE;
                w_nextLen   = '0;
            end else if (w_isAlnum) begin
                w_nextState = w_appState;
                w_nextLen   = w_appLen;
            end else if (r_state != S_IDLE) begin
                w_close     = 1'b1;
                w_closeIsId = (r_state == S_DIGIT);
                w_closeLen  = r_len;
                w_nextState = S_IDLE;
                w_nextLen   = '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_len   <= '0;
        end else begin
            r_state <= w_nextState;
            r_len   <= w_nextLen;
        end
    end

    // A close can only happen when the slot is free or being handed off this cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tokValid <= 1'b0;
            r_tokIsId  <= 1'b0;
            r_tokLen   <= '0;
        end else if (w_close) begin
            r_tokValid <= 1'b1;
            r_tokIsId  <= w_closeIsId;
            r_tokLen   <= w_closeLen;
        end else if (i_tok_ready) begin
            r_tokValid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tokCount <= '0;
            r_idCount  <= '0;
        end else if (i_clear) begin
            r_tokCount <= '0;
            r_idCount  <= '0;
        end else if (w_close) begin
            r_tokCount <= r_tokCount + CNT_W'(1);
            if (w_closeIsId) begin
                r_idCount <= r_idCount + CNT_W'(1);
            end
        end
    end

    assign o_tok_valid = r_tokValid;
    assign o_tok_is_id = r_tokIsId;
    assign o_tok_len   = r_tokLen;
    assign o_tok_count = r_tokCount;
    assign o_id_count  = r_idCount;
    assign o_busy      = (r_state != S_IDLE) || r_tokValid;

endmodule

// File: tb/tb_id_token_ctrl.sv
// Scenario tasks plus a randomized run checked against a string-level token model.
module tb_id_token_ctrl;

    localparam int TB_LEN_W = 3;
    localparam int TB_CNT_W = 4;
    localparam int LEN_MAX  = (1 << TB_LEN_W) - 1;
    localparam int CNT_MOD  = 1 << TB_CNT_W;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                inValid = 1'b0;
    logic [7:0]          inChar = 8'h00;
    logic                inLast = 1'b0;
    logic                inReady;
    logic                tokValid;
    logic                tokIsId;
    logic [TB_LEN_W-1:0] tokLen;
    logic                tokReady = 1'b1;
    logic [TB_CNT_W-1:0] tokCount;
    logic [TB_CNT_W-1:0] idCount;
    logic                clear = 1'b0;
    logic                busy;

    int errors = 0;
    int checks = 0;

    id_token_ctrl #(.LEN_W(TB_LEN_W), .CNT_W(TB_CNT_W)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_in_valid  (inValid),
        .i_in_char   (inChar),
        .i_in_last   (inLast),
        .o_in_ready  (inReady),
        .o_tok_valid (tokValid),
        .o_tok_is_id (tokIsId),
        .o_tok_len   (tokLen),
        .i_tok_ready (tokReady),
        .o_tok_count (tokCount),
        .o_id_count  (idCount),
        .i_clear     (clear),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic bit isLetter(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
    endfunction

    function automatic bit isDigit(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    function automatic logic [7:0] randChar();
        logic [7:0] edgeDelims [8] = '{8'h2F, 8'h3A, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'h00, 8'hFF};
        logic [7:0] c;
        case ($urandom_range(0, 9))
            0, 1:    c = 8'h61 + 8'($urandom_range(0, 25));
            2, 3:    c = 8'h41 + 8'($urandom_range(0, 25));
            4, 5, 6: c = 8'h30 + 8'($urandom_range(0, 9));
            7:       c = edgeDelims[$urandom_range(0, 7)];
            default: begin
                c = 8'($urandom_range(0, 255));
                while (isLetter(c) || isDigit(c)) c = 8'($urandom_range(0, 255));
            end
        endcase
        return c;
    endfunction

    task automatic applyStimulus(input logic [7:0] c, input bit last);
        inValid = 1'b1;
        inChar  = c;
        inLast  = last;
        @(posedge clk); #1;
        inValid = 1'b0;
        inLast  = 1'b0;
        inChar  = 8'h00;
    endtask

    task automatic sendString(input string s, input bit lastOnEnd);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(s[i], lastOnEnd && (i == s.len() - 1));
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        inValid = 1'b0; inLast = 1'b0; clear = 1'b0; tokReady = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        tokReady = 1'b1;
        sendString("a1 ab", 1'b0);
        reset = 1'b1;
        #2;
        checks++;
        if ({inReady, tokValid, tokIsId, tokLen, tokCount, idCount, busy} !== {1'b1, 14'b0}) begin
            errors++;
            $display("[TB] FAIL reset_async: got rdy=%0b v=%0b id=%0b len=%0d cnt=%0d idc=%0d busy=%0b want rdy=1 rest 0",
                     inReady, tokValid, tokIsId, tokLen, tokCount, idCount, busy);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({inReady, tokValid, busy, tokCount} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL reset_release: got rdy=%0b v=%0b busy=%0b cnt=%0d want 1 0 0 0", inReady, tokValid, busy, tokCount);
        end
    endtask

    task automatic test_identifier();
        string s = "ab12";
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(s[i], 1'b0);
            checks++;
            if ({tokValid, busy} !== 2'b01) begin
                errors++;
                $display("[TB] FAIL ident_open[%0d]: got v=%0b busy=%0b want v=0 busy=1", i, tokValid, busy);
            end
        end
        applyStimulus(" ", 1'b0);
        checks++;
        if ({tokValid, tokIsId, tokLen, tokCount, idCount} !== {1'b1, 1'b1, 3'd4, 4'd1, 4'd1}) begin
            errors++;
            $display("[TB] FAIL ident_result: got v=%0b id=%0b len=%0d cnt=%0d idc=%0d want 1 1 4 1 1",
                     tokValid, tokIsId, tokLen, tokCount, idCount);
        end
        @(posedge clk); #1;
        checks++;
        if ({tokValid, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL ident_drain: got v=%0b busy=%0b want 0 0", tokValid, busy);
        end
    endtask

    task automatic test_non_identifiers();
        resetDut();
        sendString("ab ", 1'b0);
        checks++;
        if ({tokValid, tokIsId, tokLen} !== {1'b1, 1'b0, 3'd2}) begin
            errors++;
            $display("[TB] FAIL alpha_only: got v=%0b id=%0b len=%0d want 1 0 2", tokValid, tokIsId, tokLen);
        end
        sendString("9a1 ", 1'b0);
        checks++;
        if ({tokValid, tokIsId, tokLen, tokCount, idCount} !== {1'b1, 1'b0, 3'd3, 4'd2, 4'd0}) begin
            errors++;
            $display("[TB] FAIL digit_start: got v=%0b id=%0b len=%0d cnt=%0d idc=%0d want 1 0 3 2 0",
                     tokValid, tokIsId, tokLen, tokCount, idCount);
        end
    endtask

    task automatic test_last_close();
        resetDut();
        sendString("a1b2", 1'b1);
        checks++;
        if ({tokValid, tokIsId, tokLen} !== {1'b1, 1'b1, 3'd4}) begin
            errors++;
            $display("[TB] FAIL last_alnum: got v=%0b id=%0b len=%0d want 1 1 4", tokValid, tokIsId, tokLen);
        end
        @(posedge clk); #1;
        checks++;
        if ({tokValid, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL last_idle: got v=%0b busy=%0b want 0 0", tokValid, busy);
        end
        sendString("b7,", 1'b1);
        checks++;
        if ({tokValid, tokIsId, tokLen} !== {1'b1, 1'b1, 3'd2}) begin
            errors++;
            $display("[TB] FAIL last_delim: got v=%0b id=%0b len=%0d want 1 1 2", tokValid, tokIsId, tokLen);
        end
        applyStimulus(";", 1'b1);
        checks++;
        if ({tokValid, busy, tokCount} !== {1'b0, 1'b0, 4'd2}) begin
            errors++;
            $display("[TB] FAIL last_empty: got v=%0b busy=%0b cnt=%0d want 0 0 2", tokValid, busy, tokCount);
        end
    endtask

    task automatic test_backpressure();
        resetDut();
        tokReady = 1'b0;
        sendString("x9 ", 1'b0);
        inValid = 1'b1;
        inChar  = "q";
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (inReady !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_ready[%0d]: got %0b want 0", i, inReady);
            end
            @(posedge clk); #1;
            checks++;
            if ({tokValid, tokIsId, tokLen, busy} !== {1'b1, 1'b1, 3'd2, 1'b1}) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%0b id=%0b len=%0d busy=%0b want 1 1 2 1",
                         i, tokValid, tokIsId, tokLen, busy);
            end
        end
        tokReady = 1'b1;
        #1;
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_ready: got %0b want 1", inReady);
        end
        @(posedge clk); #1;
        inValid = 1'b0;
        checks++;
        if ({tokValid, busy} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL release_handoff: got v=%0b busy=%0b want 0 1", tokValid, busy);
        end
        sendString("7 ", 1'b0);
        checks++;
        if ({tokValid, tokIsId, tokLen, tokCount, idCount} !== {1'b1, 1'b1, 3'd2, 4'd2, 4'd2}) begin
            errors++;
            $display("[TB] FAIL resume_result: got v=%0b id=%0b len=%0d cnt=%0d idc=%0d want 1 1 2 2 2",
                     tokValid, tokIsId, tokLen, tokCount, idCount);
        end
    endtask

    task automatic test_saturation();
        string quiet = "  ,,";
        resetDut();
        sendString("abcdefghij1 ", 1'b0);
        checks++;
        if ({tokValid, tokIsId, tokLen} !== {1'b1, 1'b1, 3'd7}) begin
            errors++;
            $display("[TB] FAIL sat_long: got v=%0b id=%0b len=%0d want 1 1 7", tokValid, tokIsId, tokLen);
        end
        sendString("abcde1 ", 1'b0);
        checks++;
        if ({tokValid, tokLen} !== {1'b1, 3'd6}) begin
            errors++;
            $display("[TB] FAIL sat_below: got v=%0b len=%0d want 1 6", tokValid, tokLen);
        end
        sendString("abcdef1 ", 1'b0);
        checks++;
        if ({tokValid, tokLen} !== {1'b1, 3'd7}) begin
            errors++;
            $display("[TB] FAIL sat_exact: got v=%0b len=%0d want 1 7", tokValid, tokLen);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(quiet[i], 1'b0);
            checks++;
            if ({tokValid, busy, tokCount} !== {1'b0, 1'b0, 4'd3}) begin
                errors++;
                $display("[TB] FAIL delim_only[%0d]: got v=%0b busy=%0b cnt=%0d want 0 0 3", i, tokValid, busy, tokCount);
            end
        end
    endtask

    task automatic test_reset_mid_token();
        resetDut();
        sendString("a1 ab", 1'b0);
        reset = 1'b1;
        #2;
        checks++;
        if ({inReady, tokValid, tokIsId, tokLen, tokCount, idCount, busy} !== {1'b1, 14'b0}) begin
            errors++;
            $display("[TB] FAIL mid_reset: got rdy=%0b v=%0b id=%0b len=%0d cnt=%0d idc=%0d busy=%0b want rdy=1 rest 0",
                     inReady, tokValid, tokIsId, tokLen, tokCount, idCount, busy);
        end
        @(posedge clk); #1 reset = 1'b0;
        sendString("c3 ", 1'b0);
        checks++;
        if ({tokValid, tokIsId, tokLen, tokCount, idCount} !== {1'b1, 1'b1, 3'd2, 4'd1, 4'd1}) begin
            errors++;
            $display("[TB] FAIL after_reset: got v=%0b id=%0b len=%0d cnt=%0d idc=%0d want 1 1 2 1 1",
                     tokValid, tokIsId, tokLen, tokCount, idCount);
        end
    endtask

    task automatic test_clear();
        resetDut();
        sendString("a1 b2 z5", 1'b0);
        clear = 1'b1;
        applyStimulus(" ", 1'b0);
        clear = 1'b0;
        checks++;
        if ({tokValid, tokIsId, tokLen, tokCount, idCount} !== {1'b1, 1'b1, 3'd2, 4'd0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL clear_wins: got v=%0b id=%0b len=%0d cnt=%0d idc=%0d want 1 1 2 0 0",
                     tokValid, tokIsId, tokLen, tokCount, idCount);
        end
        sendString("k ", 1'b0);
        checks++;
        if ({tokCount, idCount} !== {4'd1, 4'd0}) begin
            errors++;
            $display("[TB] FAIL post_clear: got cnt=%0d idc=%0d want 1 0", tokCount, idCount);
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++;
        if ({tokCount, idCount} !== 8'd0) begin
            errors++;
            $display("[TB] FAIL clear_pulse: got cnt=%0d idc=%0d want 0 0", tokCount, idCount);
        end
    endtask

    task automatic test_counter_wrap();
        resetDut();
        for (int i = 0; i < 17; i++) sendString("a1 ", 1'b0);
        sendString("9 ", 1'b0);
        checks++;
        if ({tokCount, idCount} !== {4'd2, 4'd1}) begin
            errors++;
            $display("[TB] FAIL count_wrap: got cnt=%0d idc=%0d want 2 1", tokCount, idCount);
        end
    endtask

    task automatic test_back_to_back();
        resetDut();
        sendString("a1", 1'b1);
        checks++;
        if ({tokValid, tokIsId, tokLen} !== {1'b1, 1'b1, 3'd2}) begin
            errors++;
            $display("[TB] FAIL b2b_first: got v=%0b id=%0b len=%0d want 1 1 2", tokValid, tokIsId, tokLen);
        end
        applyStimulus("9", 1'b1);
        checks++;
        if ({tokValid, tokIsId, tokLen, tokCount} !== {1'b1, 1'b0, 3'd1, 4'd2}) begin
            errors++;
            $display("[TB] FAIL b2b_second: got v=%0b id=%0b len=%0d cnt=%0d want 1 0 1 2", tokValid, tokIsId, tokLen, tokCount);
        end
        @(posedge clk); #1;
        checks++;
        if ({tokValid, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got v=%0b busy=%0b want 0 0", tokValid, busy);
        end
    endtask

    // Model: buffer the open token as a string; classify it only when it closes.
    task automatic test_random();
        logic [7:0] tokBuf[$];
        bit mValid = 0, mId = 0;
        int mLen = 0, mTok = 0, mIdc = 0;
        bit v, l, r, cl, accept, closeNow;
        logic [7:0] c;
        resetDut();
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = randChar();
            l = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 63) == 0);
            inValid = v; inChar = c; inLast = l; tokReady = r; clear = cl;
            #1;
            checks++;
            if ({inReady, tokValid, busy} !== {(!mValid || r), mValid, (tokBuf.size() > 0 || mValid)}) begin
                errors++;
                $display("[TB] FAIL rnd_flags@%0d: got rdy=%0b v=%0b busy=%0b want %0b %0b %0b", i, inReady, tokValid, busy,
                         (!mValid || r), mValid, (tokBuf.size() > 0 || mValid));
            end
            checks++;
            if ({tokCount, idCount} !== {TB_CNT_W'(mTok), TB_CNT_W'(mIdc)}) begin
                errors++;
                $display("[TB] FAIL rnd_counts@%0d: got cnt=%0d idc=%0d want %0d %0d", i, tokCount, idCount, mTok, mIdc);
            end
            if (mValid) begin
                checks++;
                if ({tokIsId, tokLen} !== {mId, TB_LEN_W'(mLen)}) begin
                    errors++;
                    $display("[TB] FAIL rnd_result@%0d: got id=%0b len=%0d want %0b %0d", i, tokIsId, tokLen, mId, mLen);
                end
            end
            accept = v && (!mValid || r);
            if (mValid && r) mValid = 0;
            closeNow = 0;
            if (accept) begin
                if (isLetter(c) || isDigit(c)) begin
                    tokBuf.push_back(c);
                    closeNow = l;
                end else begin
                    closeNow = (tokBuf.size() > 0);
                end
            end
            if (closeNow) begin
                mId = isLetter(tokBuf[0]) && isDigit(tokBuf[tokBuf.size() - 1]);
                mLen = (tokBuf.size() > LEN_MAX) ? LEN_MAX : tokBuf.size();
                tokBuf.delete();
                mValid = 1;
            end
            if (cl) begin
                mTok = 0; mIdc = 0;
            end else if (closeNow) begin
                mTok = (mTok + 1) % CNT_MOD;
                if (mId) mIdc = (mIdc + 1) % CNT_MOD;
            end
            @(posedge clk); #1;
        end
        inValid = 1'b0; inLast = 1'b0; clear = 1'b0; tokReady = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_identifier();
        test_non_identifiers();
        test_last_close();
        test_backpressure();
        test_saturation();
        test_reset_mid_token();
        test_clear();
        test_counter_wrap();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
